// File: rtl/box_slot_buffer.sv
// box_slot_buffer: packs AXI AW+W bursts into slots, queues them in a DEPTH-entry FIFO and launches one at a time (in: s_aw*/s_w* bursts, tran_ready; out: tran_valid, ready_fall, out_* launched slot, err_wid/err_len sticky flags)
module box_slot_buffer #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int PDATA_WIDTH   = 32,
  parameter int PLENGTH_WIDTH = 4,
  parameter int USER_WIDTH    = 4,
  parameter int DEPTH         = 2,
  localparam int MAX_BEATS = 2**PLENGTH_WIDTH,
  localparam int SW        = PDATA_WIDTH/8,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW+1
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [ID_WIDTH-1:0]            s_awid,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [PLENGTH_WIDTH-1:0]       s_awlen,
  input  logic [2:0]                     s_awsize,
  input  logic [1:0]                     s_awburst,
  input  logic [USER_WIDTH-1:0]          s_awuser,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  input  logic [ID_WIDTH-1:0]            s_wid,
  input  logic [PDATA_WIDTH-1:0]         s_wdata,
  input  logic [SW-1:0]                  s_wstrb,
  input  logic                           s_wlast,
  output logic                           tran_valid,
  input  logic                           tran_ready,
  output logic                           ready_fall,
  output logic [ID_WIDTH-1:0]            out_awid,
  output logic [ADDR_WIDTH-1:0]          out_awaddr,
  output logic [PLENGTH_WIDTH-1:0]       out_awlen,
  output logic [2:0]                     out_awsize,
  output logic [1:0]                     out_awburst,
  output logic [USER_WIDTH-1:0]          out_awuser,
  output logic [MAX_BEATS*PDATA_WIDTH-1:0] out_data,
  output logic [MAX_BEATS*SW-1:0]        out_strb,
  output logic                           err_wid,
  output logic                           err_len
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]              id;
    logic [ADDR_WIDTH-1:0]            addr;
    logic [PLENGTH_WIDTH-1:0]         len;
    logic [2:0]                       size;
    logic [1:0]                       burst;
    logic [USER_WIDTH-1:0]            user;
    logic [MAX_BEATS*PDATA_WIDTH-1:0] data;
    logic [MAX_BEATS*SW-1:0]          strb;
  } slot_t;
  typedef enum logic [1:0] {IDLE, DATA, COMMIT} state_t;
  state_t state_q, state_d;
  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];
  slot_t out_q, out_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PLENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic tran_valid_q, tran_valid_d, ready_fall_q, ready_fall_d;
  logic err_wid_q, err_wid_d, err_len_q, err_len_d;
  logic commit, launch, at_len;
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    out_d      = out_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_wid_d  = err_wid_q;
    err_len_d  = err_len_q;
    s_awready  = state_q == IDLE && count_q < CW'(DEPTH);
    s_wready   = state_q == DATA;
    at_len     = beat_cnt_q == slot_q[wr_ptr_q].len;
    commit     = state_q == COMMIT;
    // a slot in COMMIT is already complete, so it may launch in the same cycle
    launch     = !tran_valid_q && tran_ready && (count_q != '0 || commit);
    if (s_awvalid && s_awready) begin
      slot_d[wr_ptr_q].id    = s_awid;
      slot_d[wr_ptr_q].addr  = s_awaddr;
      slot_d[wr_ptr_q].len   = s_awlen;
      slot_d[wr_ptr_q].size  = s_awsize;
      slot_d[wr_ptr_q].burst = s_awburst;
      slot_d[wr_ptr_q].user  = s_awuser;
      slot_d[wr_ptr_q].strb  = '0;
      beat_cnt_d             = '0;
      state_d                = DATA;
    end
    if (s_wvalid && s_wready) begin
      slot_d[wr_ptr_q].data[beat_cnt_q*PDATA_WIDTH +: PDATA_WIDTH] = s_wdata;
      slot_d[wr_ptr_q].strb[beat_cnt_q*SW +: SW]                   = s_wstrb;
      beat_cnt_d = beat_cnt_q + PLENGTH_WIDTH'(1);
      err_wid_d  = err_wid_q | (s_wid != slot_q[wr_ptr_q].id);
      err_len_d  = err_len_q | (s_wlast ^ at_len);
      state_d    = s_wlast || at_len ? COMMIT : DATA;
    end
    if (commit) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      state_d  = IDLE;
    end
    if (launch) begin
      out_d    = slot_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d      = count_q + CW'(commit) - CW'(launch);
    tran_valid_d = launch || (tran_valid_q && !tran_ready);
    ready_fall_d = tran_valid_q && tran_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '{default: '0};
      out_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_cnt_q   <= '0;
      tran_valid_q <= 1'b0;
      ready_fall_q <= 1'b0;
      err_wid_q    <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_q        <= out_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_cnt_q   <= beat_cnt_d;
      tran_valid_q <= tran_valid_d;
      ready_fall_q <= ready_fall_d;
      err_wid_q    <= err_wid_d;
      err_len_q    <= err_len_d;
    end
  end
  assign {out_awid, out_awaddr, out_awlen, out_awsize, out_awburst, out_awuser, out_data, out_strb} = out_q;
  assign tran_valid = tran_valid_q;
  assign ready_fall = ready_fall_q;
  assign err_wid    = err_wid_q;
  assign err_len    = err_len_q;
endmodule
